// File: rtl/cam_entry_alloc_ctrl_pkg.sv
// Shared constants and types for the tag-CAM allocation controller.
package cam_entry_alloc_ctrl_pkg;

    localparam int unsigned CAM_DEPTH = 16;
    localparam int unsigned CAM_INDEX = 4;
    localparam int unsigned CAM_WIDTH = 8;
    localparam int unsigned NUM_SLOTS = 4;

    typedef struct packed {
        logic                 we;
        logic [CAM_INDEX-1:0] addr;
        logic [CAM_WIDTH-1:0] tag;
    } cam_wr_t;

    function automatic logic [CAM_INDEX:0] popcount(input logic [CAM_DEPTH-1:0] v);
        logic [CAM_INDEX:0] c;
        c = '0;
        for (int i = 0; i < int'(CAM_DEPTH); i++) begin
            c = c + {{CAM_INDEX{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/cam_entry_alloc_ctrl_pick4.sv
// Picks up to four free entries: the n-th accepted slot gets the n-th lowest free index.
module cam_free_pick4
    import cam_entry_alloc_ctrl_pkg::*;
(
    input  logic [CAM_DEPTH-1:0]                 free_map,
    input  logic [NUM_SLOTS-1:0]                 accept,
    output logic [NUM_SLOTS-1:0][CAM_INDEX-1:0]  idx,
    output logic [CAM_DEPTH-1:0]                 alloc_mask
);

    always_comb begin
        logic [CAM_DEPTH-1:0] avail;
        logic [CAM_DEPTH-1:0] pick;
        avail      = free_map;
        pick       = '0;
        alloc_mask = '0;
        idx        = '0;
        for (int k = 0; k < int'(NUM_SLOTS); k++) begin
            if (accept[k]) begin
                // Isolate the lowest set bit, then mask it out for the next slot.
                pick = avail & (~avail + CAM_DEPTH'(1));
                for (int i = 0; i < int'(CAM_DEPTH); i++) begin
                    if (pick[i]) begin
                        idx[k] = CAM_INDEX'(i);
                    end
                end
                alloc_mask = alloc_mask | pick;
                avail      = avail & ~pick;
            end
        end
    end

endmodule

// File: rtl/cam_entry_alloc_ctrl.sv
// Free-map allocator for the 4R/4W tag CAM: assigns entries, drives registered write ports,
// and exports the entry-valid vector used to mask stale CAM matches.
module cam_entry_alloc_ctrl
    import cam_entry_alloc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 req0_valid_i,
    input  logic                 req1_valid_i,
    input  logic                 req2_valid_i,
    input  logic                 req3_valid_i,
    input  logic [CAM_WIDTH-1:0] req0_tag_i,
    input  logic [CAM_WIDTH-1:0] req1_tag_i,
    input  logic [CAM_WIDTH-1:0] req2_tag_i,
    input  logic [CAM_WIDTH-1:0] req3_tag_i,
    output logic                 ready_o,
    output logic [CAM_INDEX-1:0] idx0_o,
    output logic [CAM_INDEX-1:0] idx1_o,
    output logic [CAM_INDEX-1:0] idx2_o,
    output logic [CAM_INDEX-1:0] idx3_o,
    input  logic [CAM_DEPTH-1:0] release_mask_i,
    output logic                 cam0_we_o,
    output logic                 cam1_we_o,
    output logic                 cam2_we_o,
    output logic                 cam3_we_o,
    output logic [CAM_INDEX-1:0] cam0_addr_o,
    output logic [CAM_INDEX-1:0] cam1_addr_o,
    output logic [CAM_INDEX-1:0] cam2_addr_o,
    output logic [CAM_INDEX-1:0] cam3_addr_o,
    output logic [CAM_WIDTH-1:0] cam0_tag_o,
    output logic [CAM_WIDTH-1:0] cam1_tag_o,
    output logic [CAM_WIDTH-1:0] cam2_tag_o,
    output logic [CAM_WIDTH-1:0] cam3_tag_o,
    output logic [CAM_DEPTH-1:0] entry_valid_o,
    output logic [CAM_INDEX:0]   free_cnt_o,
    output logic                 err_o
);

    logic [CAM_DEPTH-1:0]                free_map_q;
    logic [CAM_INDEX:0]                  free_cnt_q;
    cam_wr_t                             wr_q [NUM_SLOTS];
    logic                                err_q;

    logic                                ready;
    logic [NUM_SLOTS-1:0]                req_valid;
    logic [NUM_SLOTS-1:0][CAM_WIDTH-1:0] req_tag;
    logic [NUM_SLOTS-1:0]                accept;
    logic [NUM_SLOTS-1:0][CAM_INDEX-1:0] idx;
    logic [CAM_DEPTH-1:0]                alloc_mask;
    logic [CAM_DEPTH-1:0]                rel_eff;
    logic                                rel_bad;

    // Ready depends only on state so there is no valid->ready path.
    assign ready     = (free_cnt_q >= (CAM_INDEX+1)'(NUM_SLOTS));
    assign req_valid = {req3_valid_i, req2_valid_i, req1_valid_i, req0_valid_i};
    assign req_tag   = {req3_tag_i, req2_tag_i, req1_tag_i, req0_tag_i};
    assign accept    = req_valid & {NUM_SLOTS{ready && !flush_i}};
    assign rel_eff   = release_mask_i & ~free_map_q;
    assign rel_bad   = |(release_mask_i & free_map_q);

    cam_free_pick4 u_pick (
        .free_map   (free_map_q),
        .accept     (accept),
        .idx        (idx),
        .alloc_mask (alloc_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            free_map_q <= '1;
            free_cnt_q <= (CAM_INDEX+1)'(CAM_DEPTH);
            err_q      <= 1'b0;
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                wr_q[k] <= '0;
            end
        end else if (flush_i) begin
            free_map_q <= '1;
            free_cnt_q <= (CAM_INDEX+1)'(CAM_DEPTH);
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                wr_q[k].we <= 1'b0;
            end
        end else begin
            // Allocation only draws from pre-edge free entries, so it never overlaps rel_eff.
            free_map_q <= (free_map_q | release_mask_i) & ~alloc_mask;
            free_cnt_q <= free_cnt_q + popcount(rel_eff) - popcount(alloc_mask);
            if (rel_bad) begin
                err_q <= 1'b1;
            end
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                wr_q[k].we <= accept[k];
                if (accept[k]) begin
                    wr_q[k].addr <= idx[k];
                    wr_q[k].tag  <= req_tag[k];
                end
            end
        end
    end

    assign ready_o       = ready;
    assign idx0_o        = idx[0];
    assign idx1_o        = idx[1];
    assign idx2_o        = idx[2];
    assign idx3_o        = idx[3];
    assign cam0_we_o     = wr_q[0].we;
    assign cam1_we_o     = wr_q[1].we;
    assign cam2_we_o     = wr_q[2].we;
    assign cam3_we_o     = wr_q[3].we;
    assign cam0_addr_o   = wr_q[0].addr;
    assign cam1_addr_o   = wr_q[1].addr;
    assign cam2_addr_o   = wr_q[2].addr;
    assign cam3_addr_o   = wr_q[3].addr;
    assign cam0_tag_o    = wr_q[0].tag;
    assign cam1_tag_o    = wr_q[1].tag;
    assign cam2_tag_o    = wr_q[2].tag;
    assign cam3_tag_o    = wr_q[3].tag;
    assign entry_valid_o = ~free_map_q;
    assign free_cnt_o    = free_cnt_q;
    assign err_o         = err_q;

endmodule

// File: doc/cam_entry_alloc_ctrl.md
Name: cam_entry_alloc_ctrl

Overview:
- Allocation controller for the 4-read/4-write tag CAM used by issue-queue wakeup.
- Owns a free map of CAM entries and accepts up to 4 insert requests per cycle.
- Assigns free entry indices to those requests and drives the CAM's 4 write ports one cycle later.
- Returns entries to the free pool on release or flush, and exports an entry-valid vector; consumers AND this vector with CAM match outputs to mask stale tags.

Parameters:
- CAM_DEPTH, 16, number of CAM entries
- CAM_INDEX, 4, log2(CAM_DEPTH), entry index width
- CAM_WIDTH, 8, tag width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush_i  in  1  free all entries, cancel this cycle's allocations
- reqK_valid_i (K=0..3)  in  1  insert request on slot K
- reqK_tag_i (K=0..3)  in  CAM_WIDTH  tag to insert
- ready_o  out  1  all 4 slots may be accepted this cycle
- idxK_o (K=0..3)  out  CAM_INDEX  entry assigned to slot K (combinational, valid when reqK_valid_i&&ready_o)
- release_mask_i  in  CAM_DEPTH  entries to free at next edge
- camK_we_o (K=0..3)  out  1  CAM write enable port K (registered)
- camK_addr_o (K=0..3)  out  CAM_INDEX  CAM write address port K (registered)
- camK_tag_o (K=0..3)  out  CAM_WIDTH  CAM write data port K (registered)
- entry_valid_o  out  CAM_DEPTH  1 = entry occupied
- free_cnt_o  out  CAM_INDEX+1  number of free entries
- err_o  out  1  sticky: release of an already-free entry

Behaviour:
- State:
  - free_map[CAM_DEPTH]; a 1 marks a free entry.
  - free_cnt.
  - Registered write-port bank.
  - Sticky err flag.
- Reset values:
  - free_map all ones; free_cnt=CAM_DEPTH; entry_valid_o=0.
  - All camK_we_o=0; addr/tag ports=0; err_o=0.
- ready_o = (free_cnt >= 4). Depends on state only; there is no valid->ready combinational path.
- Accept: slot K is accepted iff reqK_valid_i && ready_o && !flush_i.
- Index assignment, combinational from current free_map:
  - Accepted slots are ranked in ascending slot order.
  - The n-th accepted slot receives the n-th lowest-indexed free entry.
  - idxK_o is don't-care for non-accepted slots; drive 0.
- Write ports:
  - At the edge after acceptance: camK_we_o=1, camK_addr_o=idxK_o, camK_tag_o=reqK_tag_i, all for the same K.
  - camK_we_o=0 for non-accepted slots.
  - Latency from request to CAM contents = 2 edges.
- Free-map update at each edge (no flush):
  - free_map <= (free_map | release_mask_i) & ~alloc_mask.
  - free_cnt <= free_cnt + popcount(release_mask_i & ~free_map) - popcount(alloc_mask).
- Releases and allocations in the same cycle:
  - Allocation draws only from the pre-edge free_map. A released entry is reusable from the following cycle onward.
  - An alloc bit and a valid release bit therefore never coincide.
- Bits of release_mask_i that hit already-free entries change nothing and set err_o. err_o clears only on reset.
- entry_valid_o = ~free_map. It goes high at the same edge as the write-port registers. The CAM entry becomes valid one edge after entry_valid_o rises; consumers qualify matches with both.
- flush_i at an edge:
  - free_map <= all ones; free_cnt <= CAM_DEPTH.
  - All camK_we_o <= 0; same-cycle requests are dropped.
  - A write already registered from the previous cycle still reaches the CAM, but its entry is now invalid.
  - release_mask_i is ignored. flush_i has priority over everything except reset.
- Reset mid-operation: identical to the reset values above; pending registered writes are discarded.
- Invariant: free_cnt == popcount(free_map) at all times.

Decomposition:
- Shared package: CAM_DEPTH, CAM_INDEX, CAM_WIDTH constants; write-port struct {we, addr, tag}.
- One sub-module: cam_free_pick4. It is combinational and takes free_map plus a 4-bit accept vector. It returns 4 indices and alloc_mask, using cascaded lowest-set-bit find with masking.

Test Plan:
1. Reset, then 4 valid requests with tags 0x11,0x22,0x33,0x44.
   - Same cycle: idx0..3 = 0,1,2,3.
   - Next cycle: cam0..3_we=1 with matching addr/tag.
   - free_cnt 16->12; entry_valid_o=0x000F.
2. Only req1 and req3 valid, with free_map=0xFFF0.
   - idx1=4, idx3=5; cam1_we=1 and cam3_we=1; cam0_we=0 and cam2_we=0.
3. Fill to 13 occupied (free_cnt=3), then assert 1 request.
   - ready_o=0; no write; idx ignored.
   - Release entry 2: free_cnt=4, ready_o=1 next cycle, next allocation gets entry 2 first.
4. release_mask_i=0x0001 plus 1 request in the same cycle, with entry 0 occupied and entry 4 lowest free.
   - Request gets 4, not 0; entry 0 is free after the edge.
5. Release entry 9 while it is free.
   - err_o=1 and stays high; free_cnt unchanged.
6. flush_i with 4 valid requests and 10 entries occupied.
   - No we next cycle; free_cnt=16; entry_valid_o=0.
   - Assert reset mid-stream: all outputs return to their reset values at the edge.
